mitchell_mul_pipe: RTL and testbench



---
 rtl/mitchell_pkg.sv | 37 +++
 rtl/mitchell_lod.sv | 24 ++
 rtl/mitchell_mul_pipe.sv | 142 ++++++++++++++
 tb/tb_mitchell_mul_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mitchell_pkg.sv
// Shared defaults and helpers for the pipelined Mitchell multiplier.
package mitchell_pkg;

   // Default word geometry: 1 sign bit + 15 magnitude bits, 11 of them fractional.
   localparam int DEF_BITSIZE = 16;
   localparam int DEF_FRAC    = 11;
   localparam int DEF_W       = DEF_BITSIZE - 1;
   localparam int DEF_LODW    = $clog2(DEF_W);

   // Stage 1 record (default geometry): leading-one index and left-aligned
   // fraction of each operand, product sign, and a zero-operand flag.
   typedef struct packed {
      logic                  valid;
      logic                  sign;
      logic                  zero;
      logic [DEF_LODW-1:0]   k_a;
      logic [DEF_LODW-1:0]   k_b;
      logic [DEF_W-2:0]      x_a;
      logic [DEF_W-2:0]      x_b;
   } s1_def_t;

   // Stage 2 record (default geometry): summed characteristic and the
   // summed fraction (top bit is the carry into the characteristic).
   typedef struct packed {
      logic                  valid;
      logic                  sign;
      logic                  zero;
      logic [DEF_LODW:0]     k;
      logic [DEF_W-1:0]      x;
   } s2_def_t;

   // All-ones magnitude of width w, used as the saturation value.
   function automatic logic [63:0] sat_mag(input int w);
      sat_mag = (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/mitchell_lod.sv
// Leading-one detector: reports whether any bit is set and the index of the
// most significant set bit.
module mitchell_lod #(
   parameter int WIDTH = 15,
   parameter int IDXW  = 4
) (
   input  logic [WIDTH-1:0] vec,
   output logic             found,
   output logic [IDXW-1:0]  idx
);

   // Scan upward so the highest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) begin
            found = 1'b1;
            idx   = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/mitchell_mul_pipe.sv
// Three-stage Mitchell log-domain multiplier for sign-magnitude fixed point,
// with saturation and a globally stalled valid/ready pipeline.
//
// Handshake: a pair is taken on in_valid && in_ready, a result is handed over
// on out_valid && out_ready. All stages move together when
// advance = !out_valid || out_ready, so a stalled output holds c/ovf stable
// and in_ready is low until the consumer takes it.
module mitchell_mul_pipe
   import mitchell_pkg::*;
#(
   parameter int BITSIZE = DEF_BITSIZE,
   parameter int FRAC    = DEF_FRAC,
   parameter int LODW    = $clog2(BITSIZE - 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BITSIZE-1:0] a,
   input  logic [BITSIZE-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BITSIZE-1:0] c,
   output logic               ovf
);

   localparam int W  = BITSIZE - 1;  // magnitude width
   localparam int XW = W - 1;        // fraction width below the leading one
   localparam int EW = LODW + 2;     // signed exponent width

   localparam logic [W-1:0]  SAT_MAG = W'(sat_mag(W));
   localparam logic [EW-1:0] E_FRAC  = EW'(FRAC);
   localparam logic [EW-1:0] E_W     = EW'(W);
   localparam logic [EW-1:0] E_TOP   = EW'(W - 1);

   typedef struct packed {
      logic              valid;
      logic              sign;
      logic              zero;
      logic [LODW-1:0]   k_a;
      logic [LODW-1:0]   k_b;
      logic [XW-1:0]     x_a;
      logic [XW-1:0]     x_b;
   } s1_t;

   typedef struct packed {
      logic              valid;
      logic              sign;
      logic              zero;
      logic [LODW:0]     k;
      logic [W-1:0]      x;
   } s2_t;

   s1_t s1;
   s2_t s2;

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !rst;

   // ---------------- S1: leading-one detection and normalisation
   logic            found_a, found_b;
   logic [LODW-1:0] k_a, k_b;
   logic [XW-1:0]   x_a, x_b;

   mitchell_lod #(.WIDTH(W), .IDXW(LODW)) u_lod_a (
      .vec   (a[W-1:0]),
      .found (found_a),
      .idx   (k_a)
   );

   mitchell_lod #(.WIDTH(W), .IDXW(LODW)) u_lod_b (
      .vec   (b[W-1:0]),
      .found (found_b),
      .idx   (k_b)
   );

   // Shift the leading one up to bit W-1 and keep the bits beneath it.
   assign x_a = XW'(a[W-1:0] << (LODW'(W - 1) - k_a));
   assign x_b = XW'(b[W-1:0] << (LODW'(W - 1) - k_b));

   // ---------------- S3: antilog, rescale, saturate
   logic          carry;
   logic [EW-1:0] e, rsh;
   logic [W-1:0]  mant, mag;
   logic [BITSIZE-1:0] res_c;
   logic          res_ovf;

   // A fraction carry bumps the characteristic; the remaining bits are the
   // mantissa either way, so M = 1.x[W-2:0] in both cases.
   assign carry = s2.x[W-1];
   assign e     = EW'(s2.k) + EW'(carry) - E_FRAC;
   assign mant  = {1'b1, s2.x[XW-1:0]};
   // The mantissa's leading one sits at bit W-1; it must land at bit e.
   assign rsh   = E_TOP - e;
   assign mag   = mant >> rsh;

   // Result selection: zero operand, underflow, saturation, or normal.
   always_comb begin
      res_c   = '0;
      res_ovf = 1'b0;
      if (s2.zero || e[EW-1]) begin
         res_c   = '0;
         res_ovf = 1'b0;
      end else if (e >= E_W) begin
         res_c   = {s2.sign, SAT_MAG};
         res_ovf = 1'b1;
      end else begin
         res_c   = {s2.sign, mag};
      end
   end

   // Pipeline registers; everything holds while the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= '0;
         s2        <= '0;
         out_valid <= 1'b0;
         c         <= '0;
         ovf       <= 1'b0;
      end else if (advance) begin
         s1.valid  <= in_valid;
         s1.sign   <= a[BITSIZE-1] ^ b[BITSIZE-1];
         s1.zero   <= !found_a || !found_b;
         s1.k_a    <= k_a;
         s1.k_b    <= k_b;
         s1.x_a    <= x_a;
         s1.x_b    <= x_b;

         s2.valid  <= s1.valid;
         s2.sign   <= s1.sign;
         s2.zero   <= s1.zero;
         s2.k      <= {1'b0, s1.k_a} + {1'b0, s1.k_b};
         s2.x      <= {1'b0, s1.x_a} + {1'b0, s1.x_b};

         out_valid <= s2.valid;
         c         <= res_c;
         ovf       <= res_ovf;
      end
   end

endmodule

// File: tb/tb_mitchell_mul_pipe.sv
// Bench for mitchell_mul_pipe: directed vector table, random stream with
// back-pressure against a log-domain model, and a mid-stream reset.
module tb_mitchell_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, c;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q[$];   // {ovf, c}
  real         ex_q[$];    // exact product in output LSBs, -1 when not checked

  // ---------------- clock / reset
  always #5 clk = ~clk;

  mitchell_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Log-domain reference: L = k + x as one fixed-point number, add, antilog.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    int ka, kb, la, lb, s, kk, fr, e, v;
    logic sg;
    sg = x[15] ^ y[15];
    if (x[14:0] == 15'd0 || y[14:0] == 15'd0) return 17'd0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 15; i++) begin
      if (x[i]) ka = i;
      if (y[i]) kb = i;
    end
    la = (ka << 14) + ((int'(x[14:0]) << (14 - ka)) & 16383);
    lb = (kb << 14) + ((int'(y[14:0]) << (14 - kb)) & 16383);
    s  = la + lb;
    kk = s >> 14;
    fr = s & 16383;
    e  = kk - 11;
    if (e >= 15) return {1'b1, sg, 15'h7FFF};
    if (e < 0) return 17'd0;
    v = (16384 + fr) >> (14 - e);
    return {1'b0, sg, v[14:0]};
  endfunction

  // ---------------- driver tasks
  task automatic run_vec(input vec_t v);
    int lat;
    a = v.a;
    b = v.b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_latency"}, 32'(lat), 32'd3);
    check({v.name, "_c"}, 32'(c), 32'(v.c));
    check({v.name, "_ovf"}, 32'(ovf), 32'(v.ovf));
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n);
    logic [15:0] sa[$], sb[$];
    logic [16:0] e;
    logic [15:0] c_prev;
    logic        ovf_prev;
    logic        stall_prev;
    real         ex;
    int sent, got, cyc, sh;
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0;
    c_prev = '0; ovf_prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      sh = $urandom_range(4, 13);
      sa.push_back({1'(($urandom_range(0, 1))), 15'($urandom_range(1 << sh, (2 << sh) - 1))});
      sh = $urandom_range(4, 13);
      sb.push_back({1'(($urandom_range(0, 1))), 15'($urandom_range(1 << sh, (2 << sh) - 1))});
    end
    while (got < n && cyc < 2000) begin
      in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
      if (sent < n) begin
        a = sa[sent];
        b = sb[sent];
      end
      out_ready = (cyc >= 8 && cyc < 13) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_c", 32'(c), 32'(c_prev));
        check("stall_ovf", 32'(ovf), 32'(ovf_prev));
      end
      if (out_valid && !out_ready)
        check("stall_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) begin
        e = model(a, b);
        exp_q.push_back(e);
        ex = real'(a[14:0]) * real'(b[14:0]) / 2048.0;
        ex_q.push_back((e[16] || ex < 2048.0) ? -1.0 : ex);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_output", 32'(exp_q.size()), 32'd1);
        end else begin
          e  = exp_q.pop_front();
          ex = ex_q.pop_front();
          check("stream_result", 32'({ovf, c}), 32'(e));
          if (ex > 0.0) begin
            checks++;
            if (real'(c[14:0]) < ex * 0.888 - 1.0 || real'(c[14:0]) > ex + 1.0) begin
              failures++;
              $display("FAIL stream_error actual=%0d required_near=%0f", c[14:0], ex);
            end
          end
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      c_prev = c;
      ovf_prev = ovf;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got), 32'(n));
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence
  initial begin
    vecs[0]  = '{16'h0800, 16'h0800, 16'h0800, 1'b0, "one_x_one"};
    vecs[1]  = '{16'h1800, 16'h9000, 16'hB000, 1'b0, "three_x_neg_two"};
    vecs[2]  = '{16'h0C00, 16'h0C00, 16'h1000, 1'b0, "carry_1p5_sq"};
    vecs[3]  = '{16'h4000, 16'h2000, 16'h7FFF, 1'b1, "sat_pos"};
    vecs[4]  = '{16'h4000, 16'hA000, 16'hFFFF, 1'b1, "sat_neg"};
    vecs[5]  = '{16'h0000, 16'h8800, 16'h0000, 1'b0, "zero_a"};
    vecs[6]  = '{16'h8000, 16'h0800, 16'h0000, 1'b0, "neg_zero_a"};
    vecs[7]  = '{16'h0001, 16'h0001, 16'h0000, 1'b0, "underflow_tiny"};
    vecs[8]  = '{16'h8800, 16'h8800, 16'h0800, 1'b0, "neg_x_neg"};
    vecs[9]  = '{16'h0C00, 16'h0800, 16'h0C00, 1'b0, "frac_no_carry"};
    vecs[10] = '{16'h2000, 16'h1000, 16'h4000, 1'b0, "top_bit_no_sat"};
    vecs[11] = '{16'h3000, 16'h1800, 16'h7FFF, 1'b1, "sat_by_carry"};
    vecs[12] = '{16'h0001, 16'h0800, 16'h0001, 1'b0, "one_lsb"};
    vecs[13] = '{16'h8001, 16'h0400, 16'h0000, 1'b0, "underflow_sign"};
    vecs[14] = '{16'h0A00, 16'h0E00, 16'h1000, 1'b0, "carry_1p25_1p75"};
    vecs[15] = '{16'h0A00, 16'h0A00, 16'h0C00, 1'b0, "nocarry_1p25_sq"};
    vecs[16] = '{16'h0E00, 16'h0E00, 16'h1800, 1'b0, "carry_1p75_sq"};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_c", 32'(c), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    stream(24);

    // Mid-stream reset with three pairs in flight and the output stalled.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0800 + 16'(i << 8);
      b = 16'h0800;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_c", 32'(c), 32'd0);
    run_vec('{16'h1800, 16'h0800, 16'h1800, 1'b0, "after_reset"});
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
